uart_tx_frame_ctrl: RTL and testbench

//  Transmit-side frame sequencer for the UART Tx path. Accepts a data byte plus a

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_parity_gen.sv | 41 ++++
 rtl/uart_tx_frame_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_uart_tx_frame_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the UART transmit path: parity modes, FSM states, line idle level.
package uart_pkg;

    localparam logic [1:0] PAR_NONE  = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE2 = 2'b11;

    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
    localparam logic [2:0] ST_SYNC_ENC   = 3'd1;
    localparam logic [2:0] ST_START_ENC  = 3'd2;
    localparam logic [2:0] ST_DATA_ENC   = 3'd3;
    localparam logic [2:0] ST_PARITY_ENC = 3'd4;
    localparam logic [2:0] ST_STOP_ENC   = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE   = ST_IDLE_ENC,
        ST_SYNC   = ST_SYNC_ENC,
        ST_START  = ST_START_ENC,
        ST_DATA   = ST_DATA_ENC,
        ST_PARITY = ST_PARITY_ENC,
        ST_STOP   = ST_STOP_ENC
    } tx_state_e;

endpackage

// File: rtl/uart_tx_parity_gen.sv
// Combinational parity bit and enable for the latched frame payload.
module uart_tx_parity_gen
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic [1:0]            parity_type_i,
    output logic                  parity_bit_o,
    output logic                  parity_en_o
);

    function automatic logic even_parity(input logic [DATA_WIDTH-1:0] d);
        return ^d;
    endfunction

    // Select parity polarity from the latched mode; the two "none" codes disable the slot.
    always_comb begin
        parity_bit_o = 1'b0;
        parity_en_o  = 1'b0;
        case (parity_type_i)
            PAR_ODD: begin
                parity_bit_o = ~even_parity(data_i);
                parity_en_o  = 1'b1;
            end
            PAR_EVEN: begin
                parity_bit_o = even_parity(data_i);
                parity_en_o  = 1'b1;
            end
            PAR_NONE, PAR_NONE2: begin
                parity_bit_o = 1'b0;
                parity_en_o  = 1'b0;
            end
            default: begin
                parity_bit_o = 1'b0;
                parity_en_o  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame sequencer: start, data LSB-first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN for two stop bits; default build sends one.
module uart_tx_frame_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  BaudTick,
    input  logic                  Send,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic [1:0]            ParityType,
    output logic                  TxOut,
    output logic                  Busy,
    output logic                  Done
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    tx_state_e             state_q, state_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  tx_q, tx_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [1:0]            par_type_q, par_type_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
`ifdef UART_TX_TWO_STOP_EN
    logic                  stop_cnt_q, stop_cnt_d;
`endif
    logic                  parity_bit_s;
    logic                  parity_en_s;

    uart_tx_parity_gen #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_parity_gen (
        .data_i       (data_q),
        .parity_type_i(par_type_q),
        .parity_bit_o (parity_bit_s),
        .parity_en_o  (parity_en_s)
    );

    // Next-state and next-output computation; only IDLE->SYNC ignores BaudTick.
    always_comb begin
        state_d    = state_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tx_d       = tx_q;
        data_d     = data_q;
        shreg_d    = shreg_q;
        par_type_d = par_type_q;
        bit_cnt_d  = bit_cnt_q;
`ifdef UART_TX_TWO_STOP_EN
        stop_cnt_d = stop_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                tx_d = IDLE_LEVEL;
                if (Send) begin
                    state_d    = ST_SYNC;
                    busy_d     = 1'b1;
                    data_d     = DataIn;
                    shreg_d    = DataIn;
                    par_type_d = ParityType;
                    bit_cnt_d  = '0;
                end else begin
                    busy_d = 1'b0;
                end
            end
            // Wait for a tick boundary so the start bit lasts a full period.
            ST_SYNC: begin
                if (BaudTick) begin
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end else begin
                    tx_d = IDLE_LEVEL;
                end
            end
            ST_START: begin
                if (BaudTick) begin
                    state_d   = ST_DATA;
                    tx_d      = shreg_q[0];
                    bit_cnt_d = '0;
                end else begin
                    tx_d = 1'b0;
                end
            end
            ST_DATA: begin
                if (BaudTick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        if (parity_en_s) begin
                            state_d = ST_PARITY;
                            tx_d    = parity_bit_s;
                        end else begin
                            state_d = ST_STOP;
                            tx_d    = IDLE_LEVEL;
                        end
`ifdef UART_TX_TWO_STOP_EN
                        stop_cnt_d = 1'b0;
`endif
                    end else begin
                        shreg_d   = {1'b0, shreg_q[DATA_WIDTH-1:1]};
                        tx_d      = shreg_q[1];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else begin
                    tx_d = shreg_q[0];
                end
            end
            ST_PARITY: begin
                if (BaudTick) begin
                    state_d = ST_STOP;
                    tx_d    = IDLE_LEVEL;
                end else begin
                    tx_d = parity_bit_s;
                end
            end
            ST_STOP: begin
                tx_d = IDLE_LEVEL;
                if (BaudTick) begin
`ifdef UART_TX_TWO_STOP_EN
                    if (stop_cnt_q == 1'b0) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        stop_cnt_d = 1'b0;
                        state_d    = ST_IDLE;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                    end
`else
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
`endif
                end else begin
                    state_d = ST_STOP;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                tx_d    = IDLE_LEVEL;
            end
        endcase
    end

    // State and output registers with synchronous reset; reset aborts any frame silently.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_q       <= IDLE_LEVEL;
            data_q     <= '0;
            shreg_q    <= '0;
            par_type_q <= PAR_NONE;
            bit_cnt_q  <= '0;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_q       <= tx_d;
            data_q     <= data_d;
            shreg_q    <= shreg_d;
            par_type_q <= par_type_d;
            bit_cnt_q  <= bit_cnt_d;
`ifdef UART_TX_TWO_STOP_EN
            stop_cnt_q <= stop_cnt_d;
`endif
        end
    end

    assign TxOut = tx_q;
    assign Busy  = busy_q;
    assign Done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl: bit-list reference model plus literal pins.
module tb_uart_tx_frame_ctrl;

`ifdef UART_TX_TWO_STOP_EN
    localparam int NSTOP = 2;
`else
    localparam int NSTOP = 1;
`endif

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       BaudTick = 1'b0;
    logic       Send = 1'b0;
    logic [7:0] DataIn = 8'h00;
    logic [1:0] ParityType = 2'b00;
    logic       TxOut, Busy, Done;

    uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
        .Clock(Clock), .Reset(Reset), .BaudTick(BaudTick), .Send(Send),
        .DataIn(DataIn), .ParityType(ParityType),
        .TxOut(TxOut), .Busy(Busy), .Done(Done)
    );

    always #5 Clock = ~Clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // Reference model: expected line level, busy, done and the bits still to send.
    bit m_tx = 1'b1, m_busy = 1'b0, m_done = 1'b0, m_sync = 1'b0;
    int m_bits[$];

    int tick_mode = 0, tick_per = 4, tcnt = 0, n_done = 0;
    int cap[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Parity bit required for a frame, or -1 when no parity slot is sent.
    function automatic int par_bit(input logic [7:0] d, input logic [1:0] pt);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        if (pt == 2'b01) return (ones % 2 == 0) ? 1 : 0;
        else if (pt == 2'b10) return ones % 2;
        else return -1;
    endfunction

    task automatic model_update(input bit rst, input bit tk, input bit snd,
                                input logic [7:0] d, input logic [1:0] pt);
        int p;
        if (rst) begin
            m_busy = 1'b0; m_tx = 1'b1; m_done = 1'b0; m_sync = 1'b0;
            m_bits.delete();
        end else begin
            m_done = 1'b0;
            if (!m_busy) begin
                m_tx = 1'b1;
                if (snd) begin
                    m_busy = 1'b1;
                    m_sync = 1'b1;
                    m_bits.delete();
                    m_bits.push_back(0);
                    for (int i = 0; i < 8; i++) m_bits.push_back(int'(d[i]));
                    p = par_bit(d, pt);
                    if (p >= 0) m_bits.push_back(p);
                    for (int i = 0; i < NSTOP; i++) m_bits.push_back(1);
                end
            end else if (tk) begin
                if (m_sync) begin
                    m_sync = 1'b0;
                    m_tx = m_bits.pop_front() != 0;
                end else if (m_bits.size() == 0) begin
                    m_busy = 1'b0; m_done = 1'b1; m_tx = 1'b1;
                end else begin
                    m_tx = m_bits.pop_front() != 0;
                end
            end
        end
    endtask

    // Per-cycle comparison of DUT outputs against the model, away from the active edge.
    always @(negedge Clock) begin
        if (chk_en) begin
            check("tx_out", TxOut, m_tx);
            check("busy", Busy, m_busy);
            check("done", Done, m_done);
        end
    end

    task automatic step(input bit snd, input logic [7:0] d, input logic [1:0] pt, input bit rst);
        bit tk;
        @(negedge Clock);
        case (tick_mode)
            0:       tk = (tcnt == tick_per - 1);
            1:       tk = ($urandom_range(0, 3) == 0);
            default: tk = 1'b1;
        endcase
        tcnt = (tcnt + 1) % tick_per;
        if (tk && Busy === 1'b1) cap.push_back(int'(TxOut));
        BaudTick = tk; Send = snd; DataIn = d; ParityType = pt; Reset = rst;
        @(posedge Clock);
        model_update(rst, tk, snd, d, pt);
        #1;
        if (Done === 1'b1) n_done++;
    endtask

    task automatic run_frame(input logic [7:0] d, input logic [1:0] pt, output int nticks);
        int d0 = n_done;
        cap.delete();
        step(1'b1, d, pt, 1'b0);
        for (int k = 0; k < 2000 && n_done == d0; k++) step(1'b0, 8'($urandom), 2'($urandom), 1'b0);
        check("frame_done_count", n_done - d0, 1);
        nticks = cap.size() - 1;
    endtask

    int nt, d0;
    int dpos[$];
    int ep[12] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0, 1, 1};

    initial begin
        tick_mode = 0; tick_per = 4; tcnt = 0;
        step(1'b0, 8'h00, 2'b00, 1'b1);
        chk_en = 1'b1;
        step(1'b0, 8'h00, 2'b00, 1'b1);
        step(1'b0, 8'h00, 2'b00, 1'b0);
        check("reset_txout", TxOut, 1);
        check("reset_busy", Busy, 0);
        check("reset_done", Done, 0);

        // 0x55 even parity, tick every 16 clocks
        tick_per = 16; tcnt = 0;
        run_frame(8'h55, 2'b10, nt);
        check("t1_len", nt, 10 + NSTOP);
        check("t1_sync_level", cap[0], 1);
        for (int i = 0; i < 10 + NSTOP; i++) check($sformatf("t1_bit%0d", i), cap[1 + i], ep[i]);

        // parity slots and frame lengths
        tick_per = 4; tcnt = 0;
        check("pin_par_07_odd", par_bit(8'h07, 2'b01), 0);
        check("pin_par_06_odd", par_bit(8'h06, 2'b01), 1);
        run_frame(8'h07, 2'b01, nt);
        check("t2_par07", cap[10], 0);
        check("t2_len07", nt, 10 + NSTOP);
        run_frame(8'h06, 2'b01, nt);
        check("t2_par06", cap[10], 1);
        run_frame(8'h3C, 2'b00, nt);
        check("t2_len_none00", nt, 9 + NSTOP);
        run_frame(8'h3C, 2'b11, nt);
        check("t2_len_none11", nt, 9 + NSTOP);

        // Send while busy is ignored
        tick_per = 8; tcnt = 0; d0 = n_done;
        step(1'b1, 8'hA3, 2'b10, 1'b0);
        for (int k = 0; k < 40; k++) step(1'b0, 8'($urandom), 2'($urandom), 1'b0);
        step(1'b1, 8'hFF, 2'b01, 1'b0);
        for (int k = 0; k < 400 && n_done == d0; k++) step(1'b0, 8'h00, 2'b00, 1'b0);
        for (int k = 0; k < 30; k++) step(1'b0, 8'h00, 2'b00, 1'b0);
        check("t3_single_done", n_done - d0, 1);

        // reset during data bit 3
        tcnt = 0; d0 = n_done; cap.delete();
        step(1'b1, 8'hC5, 2'b01, 1'b0);
        for (int k = 0; k < 200 && cap.size() < 5; k++) step(1'b0, 8'h00, 2'b00, 1'b0);
        check("t4_reached_bit3", cap.size(), 5);
        for (int k = 0; k < 3; k++) step(1'b0, 8'h00, 2'b00, 1'b0);
        step(1'b0, 8'h00, 2'b00, 1'b1);
        check("t4_rst_txout", TxOut, 1);
        check("t4_rst_busy", Busy, 0);
        check("t4_rst_done", Done, 0);
        for (int k = 0; k < 20; k++) step(1'b0, 8'h00, 2'b00, 1'b0);
        check("t4_no_done", n_done - d0, 0);
        run_frame(8'h3A, 2'b10, nt);
        check("t4_clean_len", nt, 10 + NSTOP);

        // back-to-back with Send held and BaudTick continuous
        tick_mode = 2; dpos.delete();
        for (int i = 0; i < 3 * (12 + NSTOP) + 2; i++) begin
            d0 = n_done;
            step(1'b1, 8'($urandom), 2'b10, 1'b0);
            if (n_done != d0) dpos.push_back(i);
        end
        check("t5_done_count", dpos.size(), 3);
        for (int k = 0; k < 3; k++) check($sformatf("t5_done_pos%0d", k), dpos[k], (12 + NSTOP) * (k + 1) - 1);
        for (int k = 0; k < 40; k++) step(1'b0, 8'h00, 2'b00, 1'b0);

        // randomized traffic with random ticks and occasional resets
        tick_mode = 1;
        for (int k = 0; k < 2500; k++)
            step($urandom_range(0, 5) == 0, 8'($urandom), 2'($urandom), $urandom_range(0, 399) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
